ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one RAM port between M0 reads, M1 writes and M1 reads.
module ram_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  input  logic [ADDR_W-1:0]     m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  output logic [ADDR_W-1:0]     s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [1:0]            gnt,
  output logic                  busy
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_RESP = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;
  logic [2:0] state;
  logic [1:0] gnt_q, last, n1, n2, win;
  logic [3:0] req;
  logic aw_done, w_done, aw_hs, w_hs;
  logic rd_req, rd_resp, wr_req, wr_resp, m0_sel;
  // req is indexed by grant code; bit 0 (no grant) is never a request
  assign req = {m1_arvalid, m1_awvalid & m1_wvalid, m0_arvalid, 1'b0};
  assign n1 = last == 2'd3 ? 2'd1 : last + 2'd1;
  assign n2 = n1 == 2'd3 ? 2'd1 : n1 + 2'd1;
  assign win = req[n1] ? n1 : req[n2] ? n2 : req[last] ? last : 2'd0;
  // outputs are forced quiet while reset is held, not just after the edge
  assign rd_req  = !rst && state == RD_REQ;
  assign rd_resp = !rst && state == RD_RESP;
  assign wr_req  = !rst && state == WR_REQ;
  assign wr_resp = !rst && state == WR_RESP;
  assign busy    = !rst && state != IDLE;
  assign gnt     = rst ? 2'd0 : gnt_q;
  assign m0_sel  = gnt_q == 2'd1;
  assign s_araddr   = rd_req ? (m0_sel ? m0_araddr : m1_araddr) : '0;
  assign s_arvalid  = rd_req;
  assign m0_arready = rd_req & m0_sel & s_arready;
  assign m1_arready = rd_req & !m0_sel & s_arready;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_rvalid  = rd_resp & m0_sel & s_rvalid;
  assign m1_rvalid  = rd_resp & !m0_sel & s_rvalid;
  assign s_rready   = rd_resp & (m0_sel ? m0_rready : m1_rready);
  assign s_awaddr   = wr_req ? m1_awaddr : '0;
  assign s_wdata    = wr_req ? m1_wdata : '0;
  assign s_wstrb    = wr_req ? m1_wstrb : '0;
  assign s_awvalid  = wr_req & !aw_done;
  assign s_wvalid   = wr_req & !w_done;
  assign aw_hs      = s_awvalid & s_awready;
  assign w_hs       = s_wvalid & s_wready;
  assign m1_awready = aw_hs;
  assign m1_wready  = w_hs;
  assign m1_bvalid  = wr_resp & s_bvalid;
  assign s_bready   = wr_resp & m1_bready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt_q   <= 2'd0;
      last    <= 2'd3;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win != 2'd0) begin
          gnt_q   <= win;
          last    <= win;
          state   <= win == 2'd2 ? WR_REQ : RD_REQ;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        RD_REQ: if (s_arready) state <= RD_RESP;
        RD_RESP: if (s_rvalid & s_rready) begin
          state <= IDLE;
          gnt_q <= 2'd0;
        end
        WR_REQ: begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
          if ((aw_done | aw_hs) & (w_done | w_hs)) state <= WR_RESP;
        end
        WR_RESP: if (s_bvalid & m1_bready) begin
          state <= IDLE;
          gnt_q <= 2'd0;
        end
        default: begin
          state <= IDLE;
          gnt_q <= 2'd0;
        end
      endcase
    end
  end
endmodule
